ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipeline_pkg.sv | 82 ++++++++
 rtl/ctrl_pipeline_if.sv | 34 +++
 rtl/ctrl_pipeline_hazard_fwd.sv | 52 +++++
 rtl/ctrl_pipeline.sv | 99 +++++++++
 tb/tb_ctrl_pipeline.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipeline_pkg.sv
// Shared rv32i pipeline-control encodings: ALU selects, forwarding selects,
// per-stage control records and their bubble values.
package ctrl_pipeline_pkg;

  typedef enum logic [1:0] {
    ULA_ADD    = 2'b00,
    ULA_SUB    = 2'b01,
    ULA_FUNCT  = 2'b10,
    ULA_BRANCH = 2'b11
  } ula_op_e;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'b00,
    SRC1_PC   = 2'b01,
    SRC1_ZERO = 2'b10,
    SRC1_RSV  = 2'b11
  } alu_src1_e;

  typedef enum logic [1:0] {
    SRC2_RS2  = 2'b00,
    SRC2_IMM  = 2'b01,
    SRC2_FOUR = 2'b10,
    SRC2_RSV  = 2'b11
  } alu_src2_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_RSV = 2'b11
  } fwd_e;

  typedef struct packed {
    logic      mem_rd;
    logic      mem_wr;
    logic      reg_wr;
    logic      mux_reg_wr;
    logic      jump;
    logic      branch;
    logic      jalr;
    ula_op_e   ula_op;
    alu_src1_e alu_src1;
    alu_src2_e alu_src2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mux_reg_wr;
    logic [4:0] rd;
  } exmem_t;

  typedef struct packed {
    logic       reg_wr;
    logic       mux_reg_wr;
    logic [4:0] rd;
  } memwb_t;

  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

  // A load in MEM has no result yet, so it never forwards from MEM; x0 never forwards.
  function automatic fwd_e fwd_select(input logic       mem_reg_wr,
                                      input logic       mem_is_load,
                                      input logic [4:0] mem_rd,
                                      input logic       wb_reg_wr,
                                      input logic [4:0] wb_rd,
                                      input logic [4:0] rs);
    if (mem_reg_wr && !mem_is_load && (mem_rd != '0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_reg_wr && (wb_rd != '0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Control-pipeline bus: ID-stage control in, EX/MEM/WB control and hazard controls out.
interface ctrl_pipeline_if;
  logic       id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr;
  logic       id_jump, id_branch, id_jalr;
  logic [1:0] id_ula_op, id_alu_src1, id_alu_src2;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect;

  logic [1:0] ex_ula_op, ex_alu_src1, ex_alu_src2;
  logic       ex_branch, ex_jump, ex_jalr;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic       mem_mem_rd, mem_mem_wr;
  logic [4:0] mem_rd_idx;
  logic       wb_reg_wr, wb_mux_reg_wr;
  logic [4:0] wb_rd_idx;
  logic       pc_wr_en, ifid_wr_en, ifid_flush;
  logic [1:0] fwd_a, fwd_b;

  modport master (
    output id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_jump, id_branch, id_jalr,
           id_ula_op, id_alu_src1, id_alu_src2, id_rs1, id_rs2, id_rd, ex_redirect,
    input  ex_ula_op, ex_alu_src1, ex_alu_src2, ex_branch, ex_jump, ex_jalr,
           ex_rs1, ex_rs2, ex_rd, mem_mem_rd, mem_mem_wr, mem_rd_idx,
           wb_reg_wr, wb_mux_reg_wr, wb_rd_idx, pc_wr_en, ifid_wr_en, ifid_flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_jump, id_branch, id_jalr,
           id_ula_op, id_alu_src1, id_alu_src2, id_rs1, id_rs2, id_rd, ex_redirect,
    output ex_ula_op, ex_alu_src1, ex_alu_src2, ex_branch, ex_jump, ex_jalr,
           ex_rs1, ex_rs2, ex_rd, mem_mem_rd, mem_mem_wr, mem_rd_idx,
           wb_reg_wr, wb_mux_reg_wr, wb_rd_idx, pc_wr_en, ifid_wr_en, ifid_flush, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_pipeline_hazard_fwd.sv
// Combinational load-use / redirect hazard detection and EX operand forwarding select.
module hazard_fwd
  import ctrl_pipeline_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_redirect,
  input  logic       idex_mem_rd,
  input  logic [4:0] idex_rd,
  input  logic [4:0] idex_rs1,
  input  logic [4:0] idex_rs2,
  input  logic       exmem_reg_wr,
  input  logic       exmem_mem_rd,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_reg_wr,
  input  logic [4:0] memwb_rd,
  output logic       pc_wr_en,
  output logic       ifid_wr_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output fwd_e       fwd_a,
  output fwd_e       fwd_b
);

  logic load_use;

  always_comb begin
    load_use = idex_mem_rd && (idex_rd != '0) &&
               ((idex_rd == id_rs1) || (idex_rd == id_rs2));

    pc_wr_en    = 1'b1;
    ifid_wr_en  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    // Redirect flushes the wrong-path instruction in ID, so a stall on it is moot.
    if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_wr_en    = 1'b0;
      ifid_wr_en  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    fwd_a = fwd_select(exmem_reg_wr, exmem_mem_rd, exmem_rd, memwb_reg_wr, memwb_rd, idex_rs1);
    fwd_b = fwd_select(exmem_reg_wr, exmem_mem_rd, exmem_rd, memwb_reg_wr, memwb_rd, idex_rs2);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with hazard and forwarding control.
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
(
  input logic            clk,
  input logic            rst,
  ctrl_pipeline_if.slave bus
);

  idex_t  idex, idex_d, idex_cap;
  exmem_t exmem, exmem_d;
  memwb_t memwb, memwb_d;
  logic   idex_bubble;
  fwd_e   fwd_a, fwd_b;

  hazard_fwd u_hazard_fwd (
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .ex_redirect  (bus.ex_redirect),
    .idex_mem_rd  (idex.mem_rd),
    .idex_rd      (idex.rd),
    .idex_rs1     (idex.rs1),
    .idex_rs2     (idex.rs2),
    .exmem_reg_wr (exmem.reg_wr),
    .exmem_mem_rd (exmem.mem_rd),
    .exmem_rd     (exmem.rd),
    .memwb_reg_wr (memwb.reg_wr),
    .memwb_rd     (memwb.rd),
    .pc_wr_en     (bus.pc_wr_en),
    .ifid_wr_en   (bus.ifid_wr_en),
    .ifid_flush   (bus.ifid_flush),
    .idex_bubble  (idex_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  always_comb begin
    idex_cap            = IDEX_BUBBLE;
    idex_cap.mem_rd     = bus.id_mem_rd;
    idex_cap.mem_wr     = bus.id_mem_wr;
    // Branches, stores and x0 destinations never write the register file.
    idex_cap.reg_wr     = bus.id_reg_wr && !bus.id_branch && !bus.id_mem_wr && (bus.id_rd != '0);
    idex_cap.mux_reg_wr = bus.id_mux_reg_wr;
    idex_cap.jump       = bus.id_jump;
    idex_cap.branch     = bus.id_branch;
    idex_cap.jalr       = bus.id_jalr;
    idex_cap.ula_op     = ula_op_e'(bus.id_ula_op);
    idex_cap.alu_src1   = alu_src1_e'(bus.id_alu_src1);
    idex_cap.alu_src2   = alu_src2_e'(bus.id_alu_src2);
    idex_cap.rs1        = bus.id_rs1;
    idex_cap.rs2        = bus.id_rs2;
    idex_cap.rd         = bus.id_rd;

    idex_d = idex_bubble ? IDEX_BUBBLE : idex_cap;

    exmem_d            = EXMEM_BUBBLE;
    exmem_d.mem_rd     = idex.mem_rd;
    exmem_d.mem_wr     = idex.mem_wr;
    exmem_d.reg_wr     = idex.reg_wr;
    exmem_d.mux_reg_wr = idex.mux_reg_wr;
    exmem_d.rd         = idex.rd;

    memwb_d            = MEMWB_BUBBLE;
    memwb_d.reg_wr     = exmem.reg_wr;
    memwb_d.mux_reg_wr = exmem.mux_reg_wr;
    memwb_d.rd         = exmem.rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= IDEX_BUBBLE;
      exmem <= EXMEM_BUBBLE;
      memwb <= MEMWB_BUBBLE;
    end else begin
      idex  <= idex_d;
      exmem <= exmem_d;
      memwb <= memwb_d;
    end
  end

  assign bus.ex_ula_op     = idex.ula_op;
  assign bus.ex_alu_src1   = idex.alu_src1;
  assign bus.ex_alu_src2   = idex.alu_src2;
  assign bus.ex_branch     = idex.branch;
  assign bus.ex_jump       = idex.jump;
  assign bus.ex_jalr       = idex.jalr;
  assign bus.ex_rs1        = idex.rs1;
  assign bus.ex_rs2        = idex.rs2;
  assign bus.ex_rd         = idex.rd;
  assign bus.mem_mem_rd    = exmem.mem_rd;
  assign bus.mem_mem_wr    = exmem.mem_wr;
  assign bus.mem_rd_idx    = exmem.rd;
  assign bus.wb_reg_wr     = memwb.reg_wr;
  assign bus.wb_mux_reg_wr = memwb.mux_reg_wr;
  assign bus.wb_rd_idx     = memwb.rd;
  assign bus.fwd_a         = fwd_a;
  assign bus.fwd_b         = fwd_b;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed self-checking bench for ctrl_pipeline: reset, hazards, forwarding, write gating.
module tb_ctrl_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned failures = 0;

  ctrl_pipeline_if bus ();

  ctrl_pipeline dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    bus.id_mem_rd = 0; bus.id_mem_wr = 0; bus.id_reg_wr = 0; bus.id_mux_reg_wr = 0;
    bus.id_jump = 0; bus.id_branch = 0; bus.id_jalr = 0;
    bus.id_ula_op = 0; bus.id_alu_src1 = 0; bus.id_alu_src2 = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.ex_redirect = 0;
  endtask

  task automatic set_alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    clear_id();
    bus.id_reg_wr = 1; bus.id_ula_op = 2'b10; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
  endtask

  task automatic set_load(input logic [4:0] rs1, input logic [4:0] rd);
    clear_id();
    bus.id_mem_rd = 1; bus.id_reg_wr = 1; bus.id_mux_reg_wr = 1; bus.id_alu_src2 = 2'b01;
    bus.id_rs1 = rs1; bus.id_rd = rd;
  endtask

  task automatic drain();
    clear_id();
    step(); step(); step();
  endtask

  task automatic test_reset();
    clear_id();
    #2;
    checks++; if (bus.ex_rd !== 5'd0 || bus.ex_rs1 !== 5'd0 || bus.ex_rs2 !== 5'd0) begin
      $display("FAIL reset_ex_idx: got rd=%0d rs1=%0d rs2=%0d expected 0", bus.ex_rd, bus.ex_rs1, bus.ex_rs2); failures++; end
    checks++; if ({bus.ex_ula_op, bus.ex_alu_src1, bus.ex_alu_src2, bus.ex_branch, bus.ex_jump, bus.ex_jalr} !== 9'd0) begin
      $display("FAIL reset_ex_ctrl: got %0h expected 0", {bus.ex_ula_op, bus.ex_alu_src1, bus.ex_alu_src2, bus.ex_branch, bus.ex_jump, bus.ex_jalr}); failures++; end
    checks++; if ({bus.mem_mem_rd, bus.mem_mem_wr, bus.mem_rd_idx, bus.wb_reg_wr, bus.wb_mux_reg_wr, bus.wb_rd_idx} !== 14'd0) begin
      $display("FAIL reset_mem_wb: got %0h expected 0", {bus.mem_mem_rd, bus.mem_mem_wr, bus.mem_rd_idx, bus.wb_reg_wr, bus.wb_mux_reg_wr, bus.wb_rd_idx}); failures++; end
    checks++; if ({bus.pc_wr_en, bus.ifid_wr_en, bus.ifid_flush, bus.fwd_a, bus.fwd_b} !== 7'b1100000) begin
      $display("FAIL reset_hazard: got %b expected 1100000", {bus.pc_wr_en, bus.ifid_wr_en, bus.ifid_flush, bus.fwd_a, bus.fwd_b}); failures++; end
    @(negedge clk);
    rst = 0;
    step();
  endtask

  task automatic test_load_use();
    set_load(5'd2, 5'd5);
    step();
    checks++; if (bus.ex_rd !== 5'd5 || bus.ex_alu_src2 !== 2'b01) begin
      $display("FAIL lu_capture: got rd=%0d src2=%0d expected rd=5 src2=1", bus.ex_rd, bus.ex_alu_src2); failures++; end
    set_alu(5'd5, 5'd1, 5'd6);
    #1;
    checks++; if (bus.pc_wr_en !== 1'b0 || bus.ifid_wr_en !== 1'b0 || bus.ifid_flush !== 1'b0) begin
      $display("FAIL lu_stall: got pc=%b ifid=%b flush=%b expected 0 0 0", bus.pc_wr_en, bus.ifid_wr_en, bus.ifid_flush); failures++; end
    step();
    checks++; if (bus.ex_rd !== 5'd0 || bus.ex_rs1 !== 5'd0 || bus.ex_ula_op !== 2'b00) begin
      $display("FAIL lu_bubble: got rd=%0d rs1=%0d op=%0d expected 0", bus.ex_rd, bus.ex_rs1, bus.ex_ula_op); failures++; end
    checks++; if (bus.mem_mem_rd !== 1'b1 || bus.mem_rd_idx !== 5'd5) begin
      $display("FAIL lu_mem_adv: got mem_rd=%b idx=%0d expected 1 5", bus.mem_mem_rd, bus.mem_rd_idx); failures++; end
    checks++; if (bus.pc_wr_en !== 1'b1 || bus.ifid_wr_en !== 1'b1) begin
      $display("FAIL lu_release: got pc=%b ifid=%b expected 1 1", bus.pc_wr_en, bus.ifid_wr_en); failures++; end
    step();
    checks++; if (bus.ex_rs1 !== 5'd5 || bus.ex_rd !== 5'd6) begin
      $display("FAIL lu_consumer: got rs1=%0d rd=%0d expected 5 6", bus.ex_rs1, bus.ex_rd); failures++; end
    checks++; if (bus.fwd_a !== 2'b10 || bus.fwd_b !== 2'b00) begin
      $display("FAIL lu_fwd_wb: got a=%b b=%b expected 10 00", bus.fwd_a, bus.fwd_b); failures++; end
    checks++; if (bus.wb_reg_wr !== 1'b1 || bus.wb_mux_reg_wr !== 1'b1 || bus.wb_rd_idx !== 5'd5) begin
      $display("FAIL lu_wb: got wr=%b mux=%b idx=%0d expected 1 1 5", bus.wb_reg_wr, bus.wb_mux_reg_wr, bus.wb_rd_idx); failures++; end
    drain();
  endtask

  task automatic test_double_match();
    set_alu(5'd1, 5'd2, 5'd3);
    step();
    set_alu(5'd4, 5'd2, 5'd3);
    step();
    set_alu(5'd4, 5'd3, 5'd9);
    step();
    checks++; if (bus.fwd_b !== 2'b01) begin
      $display("FAIL dm_fwd_b: got %b expected 01", bus.fwd_b); failures++; end
    checks++; if (bus.fwd_a !== 2'b00) begin
      $display("FAIL dm_fwd_a: got %b expected 00", bus.fwd_a); failures++; end
    clear_id();
    step();
    checks++; if (bus.fwd_b !== 2'b00 || bus.wb_rd_idx !== 5'd3) begin
      $display("FAIL dm_after: got fwd_b=%b wb_idx=%0d expected 00 3", bus.fwd_b, bus.wb_rd_idx); failures++; end
    drain();
  endtask

  task automatic test_x0_dest();
    set_alu(5'd1, 5'd2, 5'd0);
    step();
    set_alu(5'd0, 5'd0, 5'd8);
    step();
    checks++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
      $display("FAIL x0_fwd: got a=%b b=%b expected 00 00", bus.fwd_a, bus.fwd_b); failures++; end
    clear_id();
    step();
    checks++; if (bus.wb_reg_wr !== 1'b0 || bus.wb_rd_idx !== 5'd0) begin
      $display("FAIL x0_wb: got wr=%b idx=%0d expected 0 0", bus.wb_reg_wr, bus.wb_rd_idx); failures++; end
    step();
    checks++; if (bus.wb_reg_wr !== 1'b1 || bus.wb_rd_idx !== 5'd8) begin
      $display("FAIL x0_next_wb: got wr=%b idx=%0d expected 1 8", bus.wb_reg_wr, bus.wb_rd_idx); failures++; end
    drain();
  endtask

  task automatic test_redirect();
    set_load(5'd2, 5'd5);
    step();
    set_alu(5'd5, 5'd5, 5'd7);
    bus.ex_redirect = 1;
    #1;
    checks++; if (bus.ifid_flush !== 1'b1 || bus.pc_wr_en !== 1'b1 || bus.ifid_wr_en !== 1'b1) begin
      $display("FAIL rd_hazard: got flush=%b pc=%b ifid=%b expected 1 1 1", bus.ifid_flush, bus.pc_wr_en, bus.ifid_wr_en); failures++; end
    step();
    bus.ex_redirect = 0;
    checks++; if (bus.ex_rd !== 5'd0 || bus.ex_rs1 !== 5'd0 || bus.ex_rs2 !== 5'd0) begin
      $display("FAIL rd_bubble: got rd=%0d rs1=%0d rs2=%0d expected 0", bus.ex_rd, bus.ex_rs1, bus.ex_rs2); failures++; end
    #1;
    checks++; if (bus.ifid_flush !== 1'b0 || bus.pc_wr_en !== 1'b1) begin
      $display("FAIL rd_release: got flush=%b pc=%b expected 0 1", bus.ifid_flush, bus.pc_wr_en); failures++; end
    drain();
  endtask

  task automatic test_write_gating();
    clear_id();
    bus.id_branch = 1; bus.id_reg_wr = 1; bus.id_rd = 5'd7; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_ula_op = 2'b11;
    step();
    checks++; if (bus.ex_branch !== 1'b1 || bus.ex_rd !== 5'd7 || bus.ex_ula_op !== 2'b11) begin
      $display("FAIL bg_ex: got br=%b rd=%0d op=%0d expected 1 7 3", bus.ex_branch, bus.ex_rd, bus.ex_ula_op); failures++; end
    clear_id();
    bus.id_mem_wr = 1; bus.id_reg_wr = 1; bus.id_rd = 5'd9; bus.id_alu_src2 = 2'b01;
    step();
    checks++; if (bus.mem_rd_idx !== 5'd7 || bus.mem_mem_wr !== 1'b0) begin
      $display("FAIL bg_mem: got idx=%0d mem_wr=%b expected 7 0", bus.mem_rd_idx, bus.mem_mem_wr); failures++; end
    set_alu(5'd1, 5'd1, 5'd8);
    step();
    checks++; if (bus.wb_reg_wr !== 1'b0 || bus.wb_rd_idx !== 5'd7) begin
      $display("FAIL bg_wb: got wr=%b idx=%0d expected 0 7", bus.wb_reg_wr, bus.wb_rd_idx); failures++; end
    checks++; if (bus.mem_mem_wr !== 1'b1 || bus.mem_rd_idx !== 5'd9) begin
      $display("FAIL st_mem: got mem_wr=%b idx=%0d expected 1 9", bus.mem_mem_wr, bus.mem_rd_idx); failures++; end
    clear_id();
    step();
    checks++; if (bus.wb_reg_wr !== 1'b0 || bus.wb_rd_idx !== 5'd9) begin
      $display("FAIL st_wb: got wr=%b idx=%0d expected 0 9", bus.wb_reg_wr, bus.wb_rd_idx); failures++; end
    step();
    checks++; if (bus.wb_reg_wr !== 1'b1 || bus.wb_rd_idx !== 5'd8) begin
      $display("FAIL add_wb: got wr=%b idx=%0d expected 1 8", bus.wb_reg_wr, bus.wb_rd_idx); failures++; end
    drain();
  endtask

  task automatic test_mid_reset();
    set_alu(5'd1, 5'd2, 5'd4);
    step();
    set_load(5'd2, 5'd5);
    step();
    set_alu(5'd5, 5'd0, 5'd6);
    #1;
    checks++; if (bus.pc_wr_en !== 1'b0 || bus.mem_rd_idx !== 5'd4) begin
      $display("FAIL mr_pre: got pc=%b mem_idx=%0d expected 0 4", bus.pc_wr_en, bus.mem_rd_idx); failures++; end
    #2;
    rst = 1;
    #1;
    checks++; if (bus.ex_rd !== 5'd0 || bus.ex_rs1 !== 5'd0 || bus.mem_rd_idx !== 5'd0 || bus.mem_mem_rd !== 1'b0 || bus.wb_rd_idx !== 5'd0 || bus.wb_reg_wr !== 1'b0) begin
      $display("FAIL mr_clear: got ex_rd=%0d mem_idx=%0d wb_idx=%0d expected 0 0 0", bus.ex_rd, bus.mem_rd_idx, bus.wb_rd_idx); failures++; end
    checks++; if (bus.pc_wr_en !== 1'b1 || bus.ifid_wr_en !== 1'b1 || bus.ifid_flush !== 1'b0) begin
      $display("FAIL mr_hazard: got pc=%b ifid=%b flush=%b expected 1 1 0", bus.pc_wr_en, bus.ifid_wr_en, bus.ifid_flush); failures++; end
    @(negedge clk);
    rst = 0;
    step();
    checks++; if (bus.ex_rs1 !== 5'd5 || bus.ex_rd !== 5'd6 || bus.pc_wr_en !== 1'b1) begin
      $display("FAIL mr_resume: got rs1=%0d rd=%0d pc=%b expected 5 6 1", bus.ex_rs1, bus.ex_rd, bus.pc_wr_en); failures++; end
    drain();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_double_match();
    test_x0_dest();
    test_redirect();
    test_write_gating();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
